accumulator_sequencer: RTL and testbench

//  Multi-cycle fetch/decode/execute controller for the 16-bit accumulator datapath (PC, MAR, MBR, IR, ACC, ALU, main memory).

---
 rtl/accumulator_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_accumulator_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/accumulator_sequencer.sv
// accumulator_sequencer
//   Multi-cycle fetch/decode/execute controller for the 16-bit accumulator
//   datapath. Produces every register load strobe, datapath mux select,
//   the memory write enable and the ALU opcode. The only state held here is
//   the sequencer state, the sticky illegal-op flag and the retired count.
//
// Ports
//   clock, reset_n      clock (rising edge) and asynchronous active-low reset
//   start               begin execution from address 0 (honoured only in IDLE)
//   ir_data             current IR contents
//   acc_zero            ACC == 0 from the datapath
//   pc_write/pc_sel     PC load; source 0 PC+1, 1 IR address field, 2 zero
//   mar_write/mar_sel   MAR load; source 0 PC, 1 IR address field
//   mbr_write/mbr_sel   MBR load; source 0 memory data_out, 1 ACC
//   ir_write            IR load from MBR
//   acc_write/acc_sel   ACC load; source 0 MBR, 1 ALU result
//   mem_write_enable    memory write (address MAR, data MBR)
//   alu_opcode          ALU operation select (non-zero only in E_ACC)
//   busy, halted        status; illegal_op sticky until reset
//   instr_count         retired instruction count (wraps)
//   state               current state encoding, for debug

module accumulator_sequencer #(
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [15:0]        ir_data,
    input  logic               acc_zero,
    output logic               pc_write,
    output logic [1:0]         pc_sel,
    output logic               mar_write,
    output logic               mar_sel,
    output logic               mbr_write,
    output logic               mbr_sel,
    output logic               ir_write,
    output logic               acc_write,
    output logic               acc_sel,
    output logic               mem_write_enable,
    output logic [3:0]         alu_opcode,
    output logic               busy,
    output logic               halted,
    output logic               illegal_op,
    output logic [COUNT_W-1:0] instr_count,
    output logic [3:0]         state
);

    if (ADDR_W == 0 || ADDR_W > 11) begin : g_bad_addr_w
        $error("accumulator_sequencer: ADDR_W must be in 1..11");
    end

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_F_MAR   = 4'd1,
        S_F_READ  = 4'd2,
        S_F_MBR   = 4'd3,
        S_F_IR    = 4'd4,
        S_DECODE  = 4'd5,
        S_E_MAR   = 4'd6,
        S_E_READ  = 4'd7,
        S_E_MBR   = 4'd8,
        S_E_ACC   = 4'd9,
        S_S_WRITE = 4'd10,
        S_HALTED  = 4'd11
    } state_e;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_LOAD  = 3'd1,
        OP_STORE = 3'd2,
        OP_JUMP  = 3'd3,
        OP_JUMPZ = 3'd4,
        OP_HALT  = 3'd5,
        OP_ILL6  = 3'd6,
        OP_ILL7  = 3'd7
    } subop_e;

    state_e               state_q, state_d;
    logic                 illegal_q, illegal_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic                 retire;
    logic                 illegal_set;

    logic   is_alu;
    subop_e subop;
    logic   is_store;

    // The operand address field is routed to PC/MAR by the datapath itself.
    logic unused_addr_bits;
    assign unused_addr_bits = ^ir_data[10:0];

    assign is_alu   = ir_data[15];
    assign subop    = subop_e'(ir_data[14:12]);
    assign is_store = !is_alu && (subop == OP_STORE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        illegal_set = 1'b0;
        unique case (state_q)
            S_IDLE:   if (start) state_d = S_F_MAR;
            S_F_MAR:  state_d = S_F_READ;
            S_F_READ: state_d = S_F_MBR;
            S_F_MBR:  state_d = S_F_IR;
            S_F_IR:   state_d = S_DECODE;
            S_DECODE: begin
                if (is_alu || subop == OP_LOAD || subop == OP_STORE) begin
                    state_d = S_E_MAR;
                end else if (subop == OP_HALT) begin
                    state_d = S_HALTED;
                    retire  = 1'b1;
                end else begin
                    // NOP, JUMP, JUMPZ and the illegal subops all retire here.
                    state_d     = S_F_MAR;
                    retire      = 1'b1;
                    illegal_set = (subop == OP_ILL6) || (subop == OP_ILL7);
                end
            end
            S_E_MAR:  state_d = is_store ? S_S_WRITE : S_E_READ;
            S_E_READ: state_d = S_E_MBR;
            S_E_MBR:  state_d = S_E_ACC;
            S_E_ACC: begin
                state_d = S_F_MAR;
                retire  = 1'b1;
            end
            S_S_WRITE: begin
                state_d = S_F_MAR;
                retire  = 1'b1;
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
        illegal_d = illegal_q | illegal_set;
        count_d   = count_q + COUNT_W'(retire);
    end

    always_comb begin
        pc_write         = 1'b0;
        pc_sel           = 2'd0;
        mar_write        = 1'b0;
        mar_sel          = 1'b0;
        mbr_write        = 1'b0;
        mbr_sel          = 1'b0;
        ir_write         = 1'b0;
        acc_write        = 1'b0;
        acc_sel          = 1'b0;
        mem_write_enable = 1'b0;
        alu_opcode       = 4'b0000;
        busy             = (state_q != S_IDLE) && (state_q != S_HALTED);
        halted           = (state_q == S_HALTED);
        unique case (state_q)
            S_IDLE: begin
                // Gated by reset_n so no strobe escapes while reset is held.
                if (start && reset_n) begin
                    pc_write = 1'b1;
                    pc_sel   = 2'd2;
                end
            end
            S_F_MAR:  mar_write = 1'b1;
            S_F_READ: pc_write  = 1'b1;
            S_F_MBR:  mbr_write = 1'b1;
            S_F_IR:   ir_write  = 1'b1;
            S_DECODE: begin
                if (!is_alu && subop == OP_JUMP) begin
                    pc_write = 1'b1;
                    pc_sel   = 2'd1;
                end else if (!is_alu && subop == OP_JUMPZ) begin
                    pc_write = acc_zero;
                    pc_sel   = 2'd1;
                end
            end
            S_E_MAR: begin
                mar_write = 1'b1;
                mar_sel   = 1'b1;
                if (is_store) begin
                    mbr_write = 1'b1;
                    mbr_sel   = 1'b1;
                end
            end
            S_E_MBR: mbr_write = 1'b1;
            S_E_ACC: begin
                acc_write = 1'b1;
                if (is_alu) begin
                    acc_sel    = 1'b1;
                    alu_opcode = ir_data[14:11];
                end
            end
            S_S_WRITE: mem_write_enable = 1'b1;
            default: ;
        endcase
    end

    assign illegal_op  = illegal_q;
    assign instr_count = count_q;
    assign state       = state_q;

endmodule

// File: tb/tb_accumulator_sequencer.sv
module tb_accumulator_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] ir_data;
    logic        acc_zero;
    logic        pc_write;
    logic [1:0]  pc_sel;
    logic        mar_write, mar_sel, mbr_write, mbr_sel, ir_write;
    logic        acc_write, acc_sel, mem_write_enable;
    logic [3:0]  alu_opcode;
    logic        busy, halted, illegal_op;
    logic [15:0] instr_count;
    logic [3:0]  dbg_state;

    always #5 clock = ~clock;

    accumulator_sequencer #(.ADDR_W(11), .COUNT_W(16)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .ir_data(ir_data),
        .acc_zero(acc_zero), .pc_write(pc_write), .pc_sel(pc_sel),
        .mar_write(mar_write), .mar_sel(mar_sel), .mbr_write(mbr_write),
        .mbr_sel(mbr_sel), .ir_write(ir_write), .acc_write(acc_write),
        .acc_sel(acc_sel), .mem_write_enable(mem_write_enable),
        .alu_opcode(alu_opcode), .busy(busy), .halted(halted),
        .illegal_op(illegal_op), .instr_count(instr_count), .state(dbg_state)
    );

    typedef struct packed {
        logic        pc_write;
        logic [1:0]  pc_sel;
        logic        mar_write, mar_sel, mbr_write, mbr_sel, ir_write;
        logic        acc_write, acc_sel, mem_we;
        logic [3:0]  alu;
        logic        busy, halted, illegal;
        logic [15:0] count;
    } obs_t;

    obs_t        exp_q[$];
    logic        dc_q[$];     // 1: pc_sel is don't-care for that cycle
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc_no = 0;

    // Reference model state: what the controller should be reporting.
    logic [15:0] m_count;
    logic        m_illegal;
    logic        m_halted;
    int unsigned emit_n, emit_lim;

    function automatic obs_t blank(input logic bsy);
        obs_t o;
        o = '0;
        o.busy    = bsy;
        o.illegal = m_illegal;
        o.count   = m_count;
        return o;
    endfunction

    task automatic emit(input obs_t o, input logic dc);
        if (emit_n < emit_lim) begin
            exp_q.push_back(o);
            dc_q.push_back(dc);
        end
        emit_n++;
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Expected per-cycle behaviour of one instruction from F_MAR entry,
    // derived from its class: 4 fetch cycles, decode, then execute steps.
    task automatic run_instr(input logic [15:0] ir, input logic az, input int unsigned lim);
        obs_t o;
        logic alu;
        logic [2:0] sub;
        alu = ir[15];
        sub = ir[14:12];
        ir_data  = ir;
        acc_zero = az;
        emit_n   = 0;
        emit_lim = lim;
        o = blank(1); o.mar_write = 1; emit(o, 0);
        o = blank(1); o.pc_write  = 1; emit(o, 0);
        o = blank(1); o.mbr_write = 1; emit(o, 0);
        o = blank(1); o.ir_write  = 1; emit(o, 0);
        if (alu || sub == 3'd1 || sub == 3'd2) begin
            o = blank(1); emit(o, 0);
            o = blank(1); o.mar_write = 1; o.mar_sel = 1;
            if (!alu && sub == 3'd2) begin
                o.mbr_write = 1; o.mbr_sel = 1; emit(o, 0);
                o = blank(1); o.mem_we = 1; emit(o, 0);
            end else begin
                emit(o, 0);
                o = blank(1); emit(o, 0);
                o = blank(1); o.mbr_write = 1; emit(o, 0);
                o = blank(1); o.acc_write = 1; o.acc_sel = alu;
                o.alu = alu ? ir[14:11] : 4'b0000;
                emit(o, 0);
            end
            m_count++;
        end else begin
            o = blank(1);
            if (sub == 3'd3) begin
                o.pc_write = 1; o.pc_sel = 2'd1;
                emit(o, 0);
            end else if (sub == 3'd4) begin
                o.pc_write = az; o.pc_sel = az ? 2'd1 : 2'd0;
                emit(o, !az);
            end else begin
                emit(o, 0);
            end
            m_count++;
            if (sub >= 3'd6) m_illegal = 1'b1;
            if (sub == 3'd5) m_halted = 1'b1;
        end
        step((emit_n < lim) ? emit_n : lim);
    endtask

    task automatic do_reset();
        obs_t o;
        reset_n   = 1'b0;
        m_count   = '0;
        m_illegal = 1'b0;
        m_halted  = 1'b0;
        o = blank(0);
        exp_q.push_back(o); dc_q.push_back(1'b0);
        step(1);
        reset_n = 1'b1;
        start   = 1'b0;
        o = blank(0);
        exp_q.push_back(o); dc_q.push_back(1'b0);
        step(1);
    endtask

    task automatic do_start();
        obs_t o;
        start = 1'b1;
        o = blank(0); o.pc_write = 1; o.pc_sel = 2'd2;
        exp_q.push_back(o); dc_q.push_back(1'b0);
        step(1);
        start = 1'b0;
    endtask

    function automatic logic [15:0] rand_ir();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 4))
            0, 1:    r[15] = 1'b1;
            2:       r[15:12] = 4'b0001;
            3:       r[15:12] = 4'b0010;
            default: r[15:12] = {1'b0, 3'($urandom_range(0, 4))};
        endcase
        return r;
    endfunction

    // Monitor: one expected observation per clock while the scoreboard holds work.
    always @(negedge clock) begin : monitor
        obs_t e, a;
        logic dc;
        if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            dc = dc_q.pop_front();
            a.pc_write  = pc_write;   a.pc_sel  = dc ? e.pc_sel : pc_sel;
            a.mar_write = mar_write;  a.mar_sel = mar_sel;
            a.mbr_write = mbr_write;  a.mbr_sel = mbr_sel;
            a.ir_write  = ir_write;   a.acc_write = acc_write;
            a.acc_sel   = acc_sel;    a.mem_we  = mem_write_enable;
            a.alu       = alu_opcode; a.busy    = busy;
            a.halted    = halted;     a.illegal = illegal_op;
            a.count     = instr_count;
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL obs[%0d] ir=%h got=%p want=%p", cyc_no, ir_data, a, e);
            end
            cyc_no++;
        end
    end

    initial begin
        obs_t o;
        reset_n   = 1'b0;
        start     = 1'b0;
        ir_data   = '0;
        acc_zero  = 1'b0;
        m_count   = '0;
        m_illegal = 1'b0;
        m_halted  = 1'b0;
        step(1);
        repeat (2) begin
            o = blank(0);
            exp_q.push_back(o); dc_q.push_back(1'b0);
        end
        step(2);
        reset_n = 1'b1;
        o = blank(0);
        exp_q.push_back(o); dc_q.push_back(1'b0);
        step(1);
        do_start();

        // LOAD cut off by reset while in E_READ; start held during reset.
        run_instr(16'h1005, 1'b0, 6);
        start = 1'b1;
        do_reset();
        do_start();

        // Directed instructions.
        run_instr(16'h1005, 1'b0, 99);
        run_instr(16'h8803, 1'b1, 99);
        run_instr(16'h2010, 1'b0, 99);
        run_instr(16'h4020, 1'b1, 99);
        run_instr(16'h4020, 1'b0, 99);
        run_instr(16'h0000, 1'b0, 99);
        run_instr(16'h3123, 1'b1, 99);
        run_instr(16'hF800, 1'b0, 99);

        for (int i = 0; i < 40; i++) begin
            if (i == 5) start = 1'b1;     // start outside IDLE has no effect
            if (i == 6) start = 1'b0;
            run_instr(rand_ir(), 1'($urandom), 99);
        end
        run_instr(16'h6000, 1'b0, 99);
        run_instr(16'h7ABC, 1'b1, 99);
        for (int i = 0; i < 20; i++) run_instr(rand_ir(), 1'($urandom), 99);

        run_instr(16'h5000, 1'b0, 99);
        for (int i = 0; i < 8; i++) begin
            start = 1'(i % 2);
            o = blank(0); o.halted = 1'b1;
            exp_q.push_back(o); dc_q.push_back(1'b0);
            step(1);
        end
        start = 1'b0;

        do_reset();
        do_start();
        for (int i = 0; i < 10; i++) run_instr(rand_ir(), 1'($urandom), 99);

        step(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
